// File: rtl/seq_stage_memory_if.sv
// Signal bundle around the memory-access stage: execute handshake, data-memory
// req/ack port and the write stage's native fields. slave = the stage itself.
interface seq_stage_memory_if #(
    parameter int ADDRESS_SIZE = 10,
    parameter int DATA_SIZE    = 32
);
    // execute side
    logic                        i_valid;
    logic                        i_load;
    logic                        i_store;
    logic [ADDRESS_SIZE-1:0]     i_address;
    logic [DATA_SIZE-1:0]        i_store_data;
    logic signed [DATA_SIZE-1:0] i_result;
    logic [2:0]                  i_destination;
    logic                        i_register_file_write;
    logic                        o_stall;

    // data memory
    logic                        o_mem_req;
    logic                        o_mem_we;
    logic [ADDRESS_SIZE-1:0]     o_mem_addr;
    logic [DATA_SIZE-1:0]        o_mem_wdata;
    logic                        i_mem_ack;
    logic [DATA_SIZE-1:0]        i_mem_rdata;

    // write stage
    logic                        o_valid;
    logic                        o_data_source;
    logic [2:0]                  o_destination;
    logic signed [DATA_SIZE-1:0] o_result;
    logic [DATA_SIZE-1:0]        o_data;
    logic                        o_register_file_write;
    logic                        o_mem_error;

    modport slave (
        input  i_valid, i_load, i_store, i_address, i_store_data, i_result,
               i_destination, i_register_file_write, i_mem_ack, i_mem_rdata,
        output o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
               o_valid, o_data_source, o_destination, o_result, o_data,
               o_register_file_write, o_mem_error
    );

    modport master (
        output i_valid, i_load, i_store, i_address, i_store_data, i_result,
               i_destination, i_register_file_write, i_mem_ack, i_mem_rdata,
        input  o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
               o_valid, o_data_source, o_destination, o_result, o_data,
               o_register_file_write, o_mem_error
    );
endinterface

// File: rtl/seq_stage_memory.sv
// Registered memory-access stage: one instruction per handshake, at most one
// data-memory load/store over req/ack with a bounded wait, one-cycle result out.
module seq_stage_memory #(
    parameter int ADDRESS_SIZE = 10,
    parameter int DATA_SIZE    = 32,
    parameter int ACK_TIMEOUT  = 15
) (
    input logic               i_clk,
    input logic               i_rst_n,
    seq_stage_memory_if.slave bus
);
    localparam int COUNT_WIDTH = $clog2(ACK_TIMEOUT + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_WAIT = COUNT_WIDTH'(ACK_TIMEOUT - 1);

    typedef enum logic {IDLE, MEM_WAIT} state_t;

    // fields of the memory instruction in flight, needed again at completion
    typedef struct packed {
        logic                 load;
        logic [2:0]           destination;
        logic [DATA_SIZE-1:0] result;
        logic                 register_file_write;
    } pending_t;

    typedef struct packed {
        logic                    req;
        logic                    we;
        logic [ADDRESS_SIZE-1:0] addr;
        logic [DATA_SIZE-1:0]    wdata;
    } mem_req_t;

    typedef struct packed {
        logic                 valid;
        logic                 data_source;
        logic [2:0]           destination;
        logic [DATA_SIZE-1:0] result;
        logic [DATA_SIZE-1:0] data;
        logic                 register_file_write;
        logic                 mem_error;
    } write_t;

    state_t                 state, state_d;
    logic [COUNT_WIDTH-1:0] wait_count, wait_count_d;
    pending_t               pending, pending_d;
    mem_req_t               mem, mem_d;
    write_t                 wr, wr_d;

    // NOTE: every signal driven here gets a default before the case so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d      = state;
        wait_count_d = wait_count;
        pending_d    = pending;
        mem_d        = mem;
        wr_d         = wr;
        wr_d.valid               = 1'b0;
        wr_d.register_file_write = 1'b0;
        wr_d.mem_error           = 1'b0;

        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    if (bus.i_load || bus.i_store) begin
                        state_d                       = MEM_WAIT;
                        wait_count_d                  = '0;
                        pending_d.load                = bus.i_load;
                        pending_d.destination         = bus.i_destination;
                        pending_d.result              = bus.i_result;
                        pending_d.register_file_write = bus.i_register_file_write;
                        mem_d.req                     = 1'b1;
                        // a combined load/store is a load
                        mem_d.we                      = bus.i_store & ~bus.i_load;
                        mem_d.addr                    = bus.i_address;
                        mem_d.wdata                   = bus.i_store_data;
                    end else begin
                        wr_d.valid               = 1'b1;
                        wr_d.data_source         = 1'b0;
                        wr_d.destination         = bus.i_destination;
                        wr_d.result              = bus.i_result;
                        wr_d.register_file_write = bus.i_register_file_write;
                    end
                end
            end

            MEM_WAIT: begin
                // ack is checked first so it wins over a timeout on the same edge
                if (bus.i_mem_ack) begin
                    state_d                  = IDLE;
                    mem_d.req                = 1'b0;
                    wr_d.valid               = 1'b1;
                    wr_d.data_source         = pending.load;
                    wr_d.destination         = pending.destination;
                    wr_d.result              = pending.result;
                    wr_d.register_file_write = pending.load & pending.register_file_write;
                    if (pending.load) begin
                        wr_d.data = bus.i_mem_rdata;
                    end
                end else if (wait_count == LAST_WAIT) begin
                    state_d          = IDLE;
                    mem_d.req        = 1'b0;
                    wr_d.valid       = 1'b1;
                    wr_d.data_source = 1'b0;
                    wr_d.destination = pending.destination;
                    wr_d.result      = pending.result;
                    wr_d.mem_error   = 1'b1;
                end else begin
                    wait_count_d = wait_count + COUNT_WIDTH'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            wait_count <= '0;
            pending    <= '0;
            mem        <= '0;
            wr         <= '0;
        end else begin
            state      <= state_d;
            wait_count <= wait_count_d;
            pending    <= pending_d;
            mem        <= mem_d;
            wr         <= wr_d;
        end
    end

    assign bus.o_stall               = (state == MEM_WAIT);
    assign bus.o_mem_req             = mem.req;
    assign bus.o_mem_we              = mem.we;
    assign bus.o_mem_addr            = mem.addr;
    assign bus.o_mem_wdata           = mem.wdata;
    assign bus.o_valid               = wr.valid;
    assign bus.o_data_source         = wr.data_source;
    assign bus.o_destination         = wr.destination;
    assign bus.o_result              = wr.result;
    assign bus.o_data                = wr.data;
    assign bus.o_register_file_write = wr.register_file_write;
    assign bus.o_mem_error           = wr.mem_error;
endmodule
